// File: rtl/cpu_defs.sv
// Shared types and constants for the data-side posted-write buffer.
package cpu_defs;

    localparam int WBUF_DEPTH  = 4;
    localparam int WBUF_ADDR_W = 32;

    typedef struct packed {
        logic [WBUF_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [3:0]             wstrb;
        logic [1:0]             size;
    } wbuf_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        W_ADDR,
        W_DATA,
        R_ADDR,
        R_DATA
    } wbuf_state_t;

endpackage

// File: rtl/wbuf_fifo.sv
// Synchronous FIFO of queued store entries; head is visible without a pop.
module wbuf_fifo
    import cpu_defs::*;
#(
    parameter int DEPTH = WBUF_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  wbuf_entry_t            data_i,
    output wbuf_entry_t            head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbuf_entry_t      mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i & ~full_o;
    assign doPop   = pop_i & ~empty_o;
    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-write buffer: stores are acked once queued and drained in order;
// loads pass through only when the buffer is empty to keep program order.
module data_write_buffer
    import cpu_defs::*;
#(
    parameter int DEPTH  = WBUF_DEPTH,
    parameter int ADDR_W = WBUF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic [3:0]        cpu_wstrb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic              cpu_addr_ok,
    output logic              cpu_data_ok,
    output logic [31:0]       cpu_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [31:0]       mem_rdata,
    output logic              buf_empty
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wbuf_state_t       state_q;
    wbuf_state_t       state_d;
    wbuf_entry_t       pushEntry;
    wbuf_entry_t       head;
    logic [CNT_W-1:0]  count;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              stAccept;
    logic              ldAccept;
    logic              pop;
    logic              moreStores;
    logic              readPhase;
    logic              stAck_q;
    logic              ldAck_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] rdAddr_q;
    logic [1:0]        rdSize_q;

    assign readPhase = (state_q == R_ADDR) || (state_q == R_DATA);

    // Stores stay blocked while a load is in flight or its ack is pending,
    // so the two kinds of cpu_data_ok can never collide.
    assign stAccept    = cpu_req & cpu_wr & ~fifoFull & ~readPhase & ~ldAck_q;
    assign ldAccept    = cpu_req & ~cpu_wr & fifoEmpty & (state_q == IDLE);
    assign cpu_addr_ok = stAccept | ldAccept;
    assign pop         = (state_q == W_DATA) & mem_data_ok;
    assign moreStores  = stAccept | (count != CNT_W'(1));

    assign pushEntry.addr  = WBUF_ADDR_W'(cpu_addr);
    assign pushEntry.wdata = cpu_wdata;
    assign pushEntry.wstrb = cpu_wstrb;
    assign pushEntry.size  = cpu_size;

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stAccept),
        .pop_i   (pop),
        .data_i  (pushEntry),
        .head_o  (head),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    state_d = W_ADDR;
                end else if (ldAccept) begin
                    state_d = R_ADDR;
                end
            end
            W_ADDR: if (mem_addr_ok) state_d = W_DATA;
            W_DATA: if (mem_data_ok) state_d = moreStores ? W_ADDR : IDLE;
            R_ADDR: if (mem_addr_ok) state_d = R_DATA;
            R_DATA: if (mem_data_ok) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Downstream fields come only from the FIFO head or the read register.
    always_comb begin
        mem_req   = (state_q == W_ADDR) || (state_q == R_ADDR);
        mem_wr    = 1'b1;
        mem_size  = head.size;
        mem_wstrb = head.wstrb;
        mem_addr  = ADDR_W'(head.addr);
        mem_wdata = head.wdata;
        if (readPhase) begin
            mem_wr    = 1'b0;
            mem_size  = rdSize_q;
            mem_wstrb = '0;
            mem_addr  = rdAddr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stAck_q  <= 1'b0;
            ldAck_q  <= 1'b0;
            rdata_q  <= '0;
            rdAddr_q <= '0;
            rdSize_q <= '0;
        end else begin
            stAck_q <= stAccept;
            ldAck_q <= (state_q == R_DATA) & mem_data_ok;
            if ((state_q == R_DATA) && mem_data_ok) begin
                rdata_q <= mem_rdata;
            end
            if (ldAccept) begin
                rdAddr_q <= cpu_addr;
                rdSize_q <= cpu_size;
            end
        end
    end

    assign cpu_data_ok = stAck_q | ldAck_q;
    assign cpu_rdata   = rdata_q;
    assign buf_empty   = fifoEmpty & (state_q == IDLE) & ~stAck_q & ~ldAck_q;

endmodule
